// File: rtl/nerv_lock.sv
// Password-lock peripheral: a 16-bit key is programmed, then attempts are
// verified against it; three consecutive misses lock the block out until reset.
module nerv_lock (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic        pass,
  input  logic [15:0] data_in,
  output logic [15:0] lock
);

  logic [15:0] key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic        unlocked_q, unlocked_d;
  logic [1:0]  fail_cnt_q, fail_cnt_d;
  logic        lockout_q, lockout_d;
  logic [15:0] lock_q, lock_d;

  logic        cmd_prog, cmd_verify, cmd_relock, cmd_read;
  logic [15:0] status;

  assign cmd_prog   = cs && wr && !rd && !pass;
  assign cmd_verify = cs && wr && !rd && pass;
  assign cmd_relock = cs && wr && rd;
  assign cmd_read   = cs && rd && !wr;

  assign status = {10'b0, fail_cnt_q, 1'b0, lockout_q, key_valid_q, unlocked_q};

  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    unlocked_d  = unlocked_q;
    fail_cnt_d  = fail_cnt_q;
    lockout_d   = lockout_q;
    lock_d      = lock_q;

    if (cmd_prog) begin
      // Re-keying needs either a fresh block or a currently unlocked one.
      if (!key_valid_q || unlocked_q) begin
        key_d       = data_in;
        key_valid_d = 1'b1;
        unlocked_d  = 1'b0;
        fail_cnt_d  = 2'd0;
      end
    end else if (cmd_verify) begin
      if (key_valid_q && !lockout_q) begin
        if (data_in == key_q) begin
          unlocked_d = 1'b1;
          fail_cnt_d = 2'd0;
        end else begin
          // Third miss (count was 2) lands on 3 and latches lockout.
          unlocked_d = 1'b0;
          fail_cnt_d = fail_cnt_q + 2'd1;
          if (fail_cnt_q == 2'd2) lockout_d = 1'b1;
        end
      end
    end else if (cmd_relock) begin
      unlocked_d = 1'b0;
    end

    if (cmd_read) lock_d = status;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q       <= 16'h0000;
      key_valid_q <= 1'b0;
      unlocked_q  <= 1'b0;
      fail_cnt_q  <= 2'd0;
      lockout_q   <= 1'b0;
      lock_q      <= 16'h0000;
    end else begin
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      unlocked_q  <= unlocked_d;
      fail_cnt_q  <= fail_cnt_d;
      lockout_q   <= lockout_d;
      lock_q      <= lock_d;
    end
  end

  assign lock = lock_q;

endmodule

// File: tb/tb_nerv_lock.sv
// Scoreboard bench for nerv_lock: a behavioural lock model predicts each READ
// result; a monitor compares the lock register every cycle.
module tb_nerv_lock;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0, pass = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] lock;

  int checks = 0;
  int errors = 0;

  nerv_lock dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .pass(pass),
    .data_in(data_in), .lock(lock)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_key = 16'h0000;
  bit          m_has_key = 0;
  bit          m_open = 0;
  int          m_misses = 0;

  logic [15:0] exp_q[$];
  logic        rd_seen = 1'b0;
  logic [15:0] lock_exp = 16'h0000;

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s = 16'h0000;
    s[0] = m_open;
    s[1] = m_has_key;
    s[2] = (m_misses >= 3);
    s[5:4] = m_misses[1:0];
    return s;
  endfunction

  task automatic model_reset();
    m_key = 16'h0000; m_has_key = 0; m_open = 0; m_misses = 0;
  endtask

  // Issue one bus cycle: update model, drive pins, let one edge pass.
  task automatic bus(input bit c, input bit w, input bit r, input bit p, input logic [15:0] d);
    if (c && r && !w) exp_q.push_back(model_status());
    if (c && w && r) begin
      m_open = 0;
    end else if (c && w && !p) begin
      if (!m_has_key || m_open) begin
        m_key = d; m_has_key = 1; m_open = 0; m_misses = 0;
      end
    end else if (c && w && p) begin
      if (m_has_key && m_misses < 3) begin
        if (d == m_key) begin
          m_open = 1; m_misses = 0;
        end else begin
          m_open = 0; m_misses = m_misses + 1;
        end
      end
    end
    cs = c; wr = w; rd = r; pass = p; data_in = d;
    @(posedge clk); #2;
    cs = 0; wr = 0; rd = 0; pass = 0;
  endtask

  task automatic prog(input logic [15:0] d);   bus(1, 1, 0, 0, d); endtask
  task automatic verify(input logic [15:0] d); bus(1, 1, 0, 1, d); endtask
  task automatic relock();                     bus(1, 1, 1, 0, 16'h0); endtask
  task automatic read();                       bus(1, 0, 1, 0, 16'h0); endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (lock !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset lock=%h expected=%h", lock, 16'h0000);
    end
    model_reset();
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) rd_seen <= 1'b0;
    else       rd_seen <= cs && rd && !wr;
  end

  // Monitor: lock must only move on a READ, and then to the predicted word.
  always @(negedge clk) begin
    if (reset) begin
      lock_exp = 16'h0000;
      exp_q.delete();
    end else begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_no_expect lock=%h expected=<none>", lock);
        end else begin
          lock_exp = exp_q.pop_front();
        end
      end
      checks++;
      if (lock !== lock_exp) begin
        errors++;
        $display("FAIL lock_word t=%0t lock=%h expected=%h", $time, lock, lock_exp);
      end
    end
  end

  initial begin
    logic [15:0] d;
    int op;
    reset = 1'b1;
    #12;
    reset = 1'b0;
    @(posedge clk); #2;

    // Directed plan
    read();
    prog(16'h152F); read();
    verify(16'h152F); read();
    relock(); read();
    verify(16'h1234); verify(16'h1234); read();
    verify(16'h152F); read();
    relock();
    verify(16'h0001); verify(16'h0002); verify(16'h0003); read();
    verify(16'h152F); read();
    prog(16'hAAAA); read();
    do_reset();
    read();
    bus(0, 1, 0, 0, 16'h1111); bus(0, 1, 0, 1, 16'h1111); bus(0, 0, 1, 0, 16'h0);
    verify(16'h0000); read();
    prog(16'h152F); read();
    prog(16'h0001); read();
    verify(16'h152F); prog(16'h0001); read();
    verify(16'h0001); read();
    // Held strobe: repeated PROGRAM while unlocked only takes the first
    prog(16'h4444); prog(16'h5555); read();
    verify(16'h4444); read();

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 99);
      d = ($urandom_range(0, 1) == 1) ? m_key : 16'($urandom);
      if (op < 2) do_reset();
      else if (op < 12) prog(d);
      else if (op < 45) verify(d);
      else if (op < 50) relock();
      else if (op < 80) read();
      else if (op < 88) bus(0, $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), d);
      else begin
        @(posedge clk); #2;
      end
    end

    read();
    repeat (3) begin @(posedge clk); #2; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
